// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types, encodings and helpers for the pipeline hazard controller.
// Also provides the register-address width and state-encoding macros.

`ifndef PIPE_HAZARD_CTRL_DEFINES
`define PIPE_HAZARD_CTRL_DEFINES
`define REG_32_ADDR_LEN 5
`define HZ_RUN      2'd0
`define HZ_MEM_WAIT 2'd1
`define HZ_ERR      2'd2
`endif

package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W = `REG_32_ADDR_LEN;
  localparam int unsigned ST_W  = 2;

  typedef enum logic [ST_W-1:0] {
    HZ_ST_RUN      = `HZ_RUN,
    HZ_ST_MEM_WAIT = `HZ_MEM_WAIT,
    HZ_ST_ERR      = `HZ_ERR,
    HZ_ST_RSVD     = 2'd3
  } hz_state_e;

  // Pipeline control bundle driven towards the datapath
  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_exe_bubble;
    logic pipe_freeze;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_CTRL_NONE = '0;

  localparam hz_ctrl_t HZ_CTRL_FREEZE = '{
    pc_hold:       1'b1,
    if_id_hold:    1'b1,
    if_id_flush:   1'b0,
    id_exe_bubble: 1'b0,
    pipe_freeze:   1'b1
  };

  // Controls when memory is not stalling: a taken branch beats a data hazard
  function automatic hz_ctrl_t hz_run_ctrl(input logic br_taken, input logic data_stall);
    hz_ctrl_t c;
    c = HZ_CTRL_NONE;
    if (br_taken) begin
      c.if_id_flush   = 1'b1;
      c.id_exe_bubble = 1'b1;
    end else if (data_stall) begin
      c.pc_hold       = 1'b1;
      c.if_id_hold    = 1'b1;
      c.id_exe_bubble = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_src_match.sv
// hz_src_match: one ID source operand against one in-flight destination.
// Register 0 is hard-wired to zero and therefore never matches.

module hz_src_match
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             i_use,
  input  logic [REG_W-1:0] i_src,
  input  logic             i_wb_en,
  input  logic [REG_W-1:0] i_dest,
  output logic             o_hit
);

  // Hit when the source is read, non-zero, and the producer writes it back
  assign o_hit = i_use & (i_src != '0) & i_wb_en & (i_dest == i_src);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW hazard stall, taken-branch squash and data-memory
// freeze sequencing for the 5-stage pipeline.
// Optional macro FORWARDING_EN: when defined only load-use hazards stall;
// otherwise any dependency on ID/EXE or EXE/MEM stalls.

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                        i_sys_clk,
  input  logic                        i_sys_rst,
  input  logic [`REG_32_ADDR_LEN-1:0] i_id_src1,
  input  logic [`REG_32_ADDR_LEN-1:0] i_id_src2,
  input  logic                        i_id_use_src1,
  input  logic                        i_id_use_src2,
  input  logic [`REG_32_ADDR_LEN-1:0] i_exe_dest,
  input  logic                        i_exe_wb_en,
  input  logic                        i_exe_mem_rd_en,
  input  logic [`REG_32_ADDR_LEN-1:0] i_mem_dest,
  input  logic                        i_mem_wb_en,
  input  logic                        i_br_taken,
  input  logic                        i_mem_req,
  input  logic                        i_mem_ack,
  output logic                        o_pc_hold,
  output logic                        o_if_id_hold,
  output logic                        o_if_id_flush,
  output logic                        o_id_exe_bubble,
  output logic                        o_pipe_freeze,
  output logic                        o_mem_err,
  output logic [ST_W-1:0]             o_state,
  output logic [CNT_W-1:0]            o_stall_cnt
);

  hz_state_e        r_state;
  hz_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_mem_err;
  logic             w_data_stall;
  logic             w_mem_busy;
  logic             w_wait_expired;
  hz_ctrl_t         w_run_ctrl;
  hz_ctrl_t         w_ctrl;

  assign w_mem_busy     = i_mem_req & ~i_mem_ack;
  assign w_wait_expired = (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

`ifdef FORWARDING_EN
  logic w_exe_hit1;
  logic w_exe_hit2;
  logic w_unused_mem;

  // EXE/MEM results are always forwarded, so those inputs are not needed
  assign w_unused_mem = ^{i_mem_dest, i_mem_wb_en};

  hz_src_match u_exe_hit1 (
    .i_use   (i_id_use_src1),
    .i_src   (i_id_src1),
    .i_wb_en (i_exe_wb_en),
    .i_dest  (i_exe_dest),
    .o_hit   (w_exe_hit1)
  );

  hz_src_match u_exe_hit2 (
    .i_use   (i_id_use_src2),
    .i_src   (i_id_src2),
    .i_wb_en (i_exe_wb_en),
    .i_dest  (i_exe_dest),
    .o_hit   (w_exe_hit2)
  );

  // Only a load in ID/EXE cannot be forwarded in time
  assign w_data_stall = (w_exe_hit1 | w_exe_hit2) & i_exe_mem_rd_en;
`else
  logic w_exe_hit1;
  logic w_exe_hit2;
  logic w_mem_hit1;
  logic w_mem_hit2;
  logic w_unused_rd;

  // Without forwarding the load flag does not change the stall decision
  assign w_unused_rd = i_exe_mem_rd_en;

  hz_src_match u_exe_hit1 (
    .i_use   (i_id_use_src1),
    .i_src   (i_id_src1),
    .i_wb_en (i_exe_wb_en),
    .i_dest  (i_exe_dest),
    .o_hit   (w_exe_hit1)
  );

  hz_src_match u_exe_hit2 (
    .i_use   (i_id_use_src2),
    .i_src   (i_id_src2),
    .i_wb_en (i_exe_wb_en),
    .i_dest  (i_exe_dest),
    .o_hit   (w_exe_hit2)
  );

  hz_src_match u_mem_hit1 (
    .i_use   (i_id_use_src1),
    .i_src   (i_id_src1),
    .i_wb_en (i_mem_wb_en),
    .i_dest  (i_mem_dest),
    .o_hit   (w_mem_hit1)
  );

  hz_src_match u_mem_hit2 (
    .i_use   (i_id_use_src2),
    .i_src   (i_id_src2),
    .i_wb_en (i_mem_wb_en),
    .i_dest  (i_mem_dest),
    .o_hit   (w_mem_hit2)
  );

  // Any pending write to a source must retire before ID can proceed
  assign w_data_stall = w_exe_hit1 | w_exe_hit2 | w_mem_hit1 | w_mem_hit2;
`endif

  assign w_run_ctrl = hz_run_ctrl(i_br_taken, w_data_stall);

  // State register
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) r_state <= HZ_ST_RUN;
    else           r_state <= w_state_nxt;
  end

  // Next-state: enter wait on an unacked request, give up after the timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HZ_ST_RUN: begin
        if (w_mem_busy) w_state_nxt = HZ_ST_MEM_WAIT;
      end
      HZ_ST_MEM_WAIT: begin
        if (i_mem_ack)           w_state_nxt = HZ_ST_RUN;
        else if (w_wait_expired) w_state_nxt = HZ_ST_ERR;
      end
      HZ_ST_ERR: begin
        w_state_nxt = HZ_ST_ERR;
      end
      default: begin
        w_state_nxt = HZ_ST_RUN;
      end
    endcase
  end

  // Outputs: memory freeze first, then branch/hazard; all quiet in reset
  always_comb begin
    w_ctrl = HZ_CTRL_NONE;
    if (!i_sys_rst) begin
      case (r_state)
        HZ_ST_RUN:      w_ctrl = w_mem_busy ? HZ_CTRL_FREEZE : w_run_ctrl;
        HZ_ST_MEM_WAIT: w_ctrl = i_mem_ack ? w_run_ctrl : HZ_CTRL_FREEZE;
        HZ_ST_ERR:      w_ctrl = HZ_CTRL_FREEZE;
        default:        w_ctrl = HZ_CTRL_NONE;
      endcase
    end
  end

  // Wait counter: cleared on entry to the wait, counts unacked wait cycles
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == HZ_ST_RUN && w_mem_busy) begin
      r_wait_cnt <= '0;
    end else if (r_state == HZ_ST_MEM_WAIT) begin
      r_wait_cnt <= i_mem_ack ? '0 : r_wait_cnt + CNT_W'(1);
    end
  end

  // Saturating count of PC-hold cycles
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_stall_cnt <= '0;
    end else if (w_ctrl.pc_hold && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Sticky timeout flag, raised together with the entry into ERR
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_mem_err <= 1'b0;
    end else if (w_state_nxt == HZ_ST_ERR) begin
      r_mem_err <= 1'b1;
    end
  end

  assign o_pc_hold       = w_ctrl.pc_hold;
  assign o_if_id_hold    = w_ctrl.if_id_hold;
  assign o_if_id_flush   = w_ctrl.if_id_flush;
  assign o_id_exe_bubble = w_ctrl.id_exe_bubble;
  assign o_pipe_freeze   = w_ctrl.pipe_freeze;
  assign o_mem_err       = r_mem_err;
  assign o_state         = r_state;
  assign o_stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default sizing and a small
// timeout/counter variant) driven with the same stimulus and checked every
// cycle against a behavioural model, plus directed literal scenarios.

module tb_pipe_hazard_ctrl;

  localparam int unsigned RW   = 5;
  localparam int unsigned TO_A = 255;
  localparam int unsigned CW_A = 16;
  localparam int unsigned TO_B = 3;
  localparam int unsigned CW_B = 4;
`ifdef FORWARDING_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [RW-1:0] id_src1, id_src2, exe_dest, mem_dest;
  logic use1, use2, exe_wb, exe_rd, mem_wb, br, req, ack;

  logic a_pc_hold, a_if_id_hold, a_flush, a_bubble, a_freeze, a_mem_err;
  logic [1:0] a_state;
  logic [CW_A-1:0] a_stall_cnt;
  logic b_pc_hold, b_if_id_hold, b_flush, b_bubble, b_freeze, b_mem_err;
  logic [1:0] b_state;
  logic [CW_B-1:0] b_stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO_A), .CNT_W(CW_A)) dut_a (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_id_src1(id_src1), .i_id_src2(id_src2),
    .i_id_use_src1(use1), .i_id_use_src2(use2),
    .i_exe_dest(exe_dest), .i_exe_wb_en(exe_wb), .i_exe_mem_rd_en(exe_rd),
    .i_mem_dest(mem_dest), .i_mem_wb_en(mem_wb),
    .i_br_taken(br), .i_mem_req(req), .i_mem_ack(ack),
    .o_pc_hold(a_pc_hold), .o_if_id_hold(a_if_id_hold), .o_if_id_flush(a_flush),
    .o_id_exe_bubble(a_bubble), .o_pipe_freeze(a_freeze), .o_mem_err(a_mem_err),
    .o_state(a_state), .o_stall_cnt(a_stall_cnt)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO_B), .CNT_W(CW_B)) dut_b (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_id_src1(id_src1), .i_id_src2(id_src2),
    .i_id_use_src1(use1), .i_id_use_src2(use2),
    .i_exe_dest(exe_dest), .i_exe_wb_en(exe_wb), .i_exe_mem_rd_en(exe_rd),
    .i_mem_dest(mem_dest), .i_mem_wb_en(mem_wb),
    .i_br_taken(br), .i_mem_req(req), .i_mem_ack(ack),
    .o_pc_hold(b_pc_hold), .o_if_id_hold(b_if_id_hold), .o_if_id_flush(b_flush),
    .o_id_exe_bubble(b_bubble), .o_pipe_freeze(b_freeze), .o_mem_err(b_mem_err),
    .o_state(b_state), .o_stall_cnt(b_stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit hit(input bit u, input logic [RW-1:0] s, input bit wb,
                             input logic [RW-1:0] d);
    return u && (s != 0) && wb && (s == d);
  endfunction

  function automatic bit data_stall();
    bit e, m;
    e = hit(use1, id_src1, exe_wb, exe_dest) || hit(use2, id_src2, exe_wb, exe_dest);
    m = hit(use1, id_src1, mem_wb, mem_dest) || hit(use2, id_src2, mem_wb, mem_dest);
    if (FWD != 0) return e && exe_rd;
    return e || m;
  endfunction

  bit m_valid = 1'b0;
  bit m_wait[2];
  bit m_err[2];
  int m_wlen[2];
  int m_cnt[2];
  int m_to[2]  = '{TO_A, TO_B};
  int m_max[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};

  // Control bits ordered {pc_hold, if_id_hold, flush, bubble, freeze}
  always @(negedge clk) begin : compare
    logic [4:0] exp_c, act_c;
    logic [1:0] act_st;
    logic act_err;
    int act_cnt, exp_st;
    bit stall;
    stall = data_stall();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        act_c = {a_pc_hold, a_if_id_hold, a_flush, a_bubble, a_freeze};
        act_st = a_state; act_err = a_mem_err; act_cnt = int'(a_stall_cnt);
      end else begin
        act_c = {b_pc_hold, b_if_id_hold, b_flush, b_bubble, b_freeze};
        act_st = b_state; act_err = b_mem_err; act_cnt = int'(b_stall_cnt);
      end
      if (rst)                                 exp_c = 5'b00000;
      else if (m_err[k])                       exp_c = 5'b11001;
      else if (!ack && (m_wait[k] || req))     exp_c = 5'b11001;
      else if (br)                             exp_c = 5'b00110;
      else if (stall)                          exp_c = 5'b11010;
      else                                     exp_c = 5'b00000;

      if (m_valid || rst) check(k == 0 ? "ctrl_a" : "ctrl_b", 32'(act_c), int'(exp_c));
      if (m_valid) begin
        exp_st = m_err[k] ? 2 : (m_wait[k] ? 1 : 0);
        check(k == 0 ? "state_a" : "state_b", 32'(act_st), exp_st);
        check(k == 0 ? "mem_err_a" : "mem_err_b", 32'(act_err), int'(m_err[k]));
        check(k == 0 ? "stall_cnt_a" : "stall_cnt_b", 32'(act_cnt), m_cnt[k]);
      end

      // Advance the model to what the next clock edge must produce
      if (rst) begin
        m_wait[k] = 1'b0; m_err[k] = 1'b0; m_wlen[k] = 0; m_cnt[k] = 0;
      end else if (m_valid) begin
        if (exp_c[4] && m_cnt[k] < m_max[k]) m_cnt[k]++;
        if (!m_err[k]) begin
          if (m_wait[k]) begin
            if (ack) m_wait[k] = 1'b0;
            else begin
              m_wlen[k]++;
              if (m_wlen[k] == m_to[k]) begin m_err[k] = 1'b1; m_wait[k] = 1'b0; end
            end
          end else if (req && !ack) begin
            m_wait[k] = 1'b1; m_wlen[k] = 0;
          end
        end
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    id_src1 = '0; id_src2 = '0; exe_dest = '0; mem_dest = '0;
    use1 = 0; use2 = 0; exe_wb = 0; exe_rd = 0; mem_wb = 0;
    br = 0; req = 0; ack = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    exe_rd = 1; exe_wb = 1; exe_dest = 5'd5; use1 = 1; id_src1 = 5'd5;
  endtask

  initial begin : stim
    clr();
    rst = 1;
    @(negedge clk);
    check("rst_state", 32'(a_state), 0);
    check("rst_cnt", 32'(a_stall_cnt), 0);
    check("rst_hold", 32'(a_pc_hold), 0);
    next_cycle();
    rst = 0;

    // Load-use: one bubble cycle
    load_use();
    @(negedge clk);
    check("lu_pc_hold", 32'(a_pc_hold), 1);
    check("lu_if_id_hold", 32'(a_if_id_hold), 1);
    check("lu_bubble", 32'(a_bubble), 1);
    check("lu_freeze", 32'(a_freeze), 0);
    next_cycle();
    clr();
    @(negedge clk);
    check("lu_after_hold", 32'(a_pc_hold), 0);
    check("lu_cnt", 32'(a_stall_cnt), 1);

    // Register 0 never hazards
    exe_dest = 5'd0; id_src1 = 5'd0; use1 = 1; exe_wb = 1;
    @(negedge clk);
    check("r0_hold", 32'(a_pc_hold), 0);
    check("r0_bubble", 32'(a_bubble), 0);

    // EXE/MEM dependency on src2
    next_cycle();
    clr();
    mem_dest = 5'd3; mem_wb = 1; id_src2 = 5'd3; use2 = 1;
    @(negedge clk);
    check("memdep_hold", 32'(a_pc_hold), 1 - FWD);
    next_cycle();
    clr();
    @(negedge clk);
    check("memdep_release", 32'(a_pc_hold), 0);
    check("memdep_cnt", 32'(a_stall_cnt), 2 - FWD);

    // Taken branch wins over a hazard
    next_cycle();
    load_use();
    br = 1;
    @(negedge clk);
    check("br_flush", 32'(a_flush), 1);
    check("br_bubble", 32'(a_bubble), 1);
    check("br_pc_hold", 32'(a_pc_hold), 0);

    // Memory wait: 4 unacked cycles, then ack together with a taken branch
    next_cycle();
    clr();
    req = 1;
    @(negedge clk);
    check("mw0_freeze", 32'(a_freeze), 1);
    check("mw0_state", 32'(a_state), 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      check("mw_freeze", 32'(a_freeze), 1);
      check("mw_state_a", 32'(a_state), 1);
      check("mw_state_b", 32'(b_state), 1);
    end
    next_cycle();
    ack = 1; br = 1;
    @(negedge clk);
    check("ack_freeze", 32'(a_freeze), 0);
    check("ack_flush", 32'(a_flush), 1);
    check("to_state_b", 32'(b_state), 2);
    check("to_err_b", 32'(b_mem_err), 1);
    check("to_freeze_b", 32'(b_freeze), 1);
    next_cycle();
    clr();
    @(negedge clk);
    check("post_ack_state_a", 32'(a_state), 0);
    check("err_held_b", 32'(b_state), 2);

    // Reset pulse clears ERR
    next_cycle();
    rst = 1;
    next_cycle();
    rst = 0;
    @(negedge clk);
    check("rst2_state_b", 32'(b_state), 0);
    check("rst2_err_b", 32'(b_mem_err), 0);
    check("rst2_cnt_b", 32'(b_stall_cnt), 0);

    // Saturation: 20 stall cycles
    next_cycle();
    load_use();
    repeat (20) next_cycle();
    clr();
    @(negedge clk);
    check("sat_cnt_b", 32'(b_stall_cnt), 15);
    check("sat_cnt_a", 32'(a_stall_cnt), 20);

    // Randomized traffic
    repeat (3000) begin
      next_cycle();
      rst      = ($urandom_range(0, 63) == 0);
      id_src1  = RW'($urandom_range(0, 3));
      id_src2  = RW'($urandom_range(0, 3));
      exe_dest = RW'($urandom_range(0, 3));
      mem_dest = RW'($urandom_range(0, 3));
      use1     = 1'($urandom_range(0, 1));
      use2     = 1'($urandom_range(0, 1));
      exe_wb   = 1'($urandom_range(0, 1));
      exe_rd   = 1'($urandom_range(0, 1));
      mem_wb   = 1'($urandom_range(0, 1));
      br       = ($urandom_range(0, 7) == 0);
      req      = ($urandom_range(0, 2) == 0);
      ack      = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It detects read-after-write hazards between the instruction in ID and the instructions already latched in ID/EXE and EXE/MEM. It squashes wrong-path instructions on a taken branch and freezes the whole pipeline while data memory is busy. Its outputs drive the PC hold, the IF/ID hold/flush, the bubble insertion into the ID/EXE register inputs (writeback, memory read and memory write enables forced to 0) and the freeze of every pipeline register.

## Interface
- MEM_TIMEOUT, 255: consecutive unacknowledged MEM_WAIT cycles before the error state; legal range 1 to 2^CNT_W-1.
- CNT_W, 16: width of the stall counter and the wait counter.
- i_sys_clk  in  1  system clock.
- i_sys_rst  in  1  reset; synchronous and active-high, one clock.
- i_id_src1, i_id_src2  in  `REG_32_ADDR_LEN  source register numbers of the instruction in ID.
- i_id_use_src1, i_id_use_src2  in  1  the ID instruction actually reads that source.
- i_exe_dest  in  `REG_32_ADDR_LEN  destination register held in ID/EXE.
- i_exe_wb_en, i_exe_mem_rd_en  in  1  writeback enable and load flag held in ID/EXE.
- i_mem_dest  in  `REG_32_ADDR_LEN  destination register held in EXE/MEM.
- i_mem_wb_en  in  1  writeback enable held in EXE/MEM.
- i_br_taken  in  1  branch resolved taken in EXE this cycle.
- i_mem_req, i_mem_ack  in  1  MEM-stage data access request, and memory ready.
- o_pc_hold  out  1  PC keeps its value.
- o_if_id_hold  out  1  IF/ID keeps its value.
- o_if_id_flush  out  1  IF/ID loads a NOP.
- o_id_exe_bubble  out  1  ID/EXE control inputs are forced to 0.
- o_pipe_freeze  out  1  ID/EXE, EXE/MEM and MEM/WB keep their values.
- o_mem_err  out  1  sticky memory-timeout flag.
- o_state  out  2  current FSM state.
- o_stall_cnt  out  CNT_W  saturating count of o_pc_hold cycles.

## Operation
- Hit rules:
  - exe_hitN = i_id_use_srcN & (i_id_srcN != 0) & i_exe_wb_en & (i_exe_dest == i_id_srcN).
  - mem_hitN uses i_mem_dest and i_mem_wb_en in the same way.
  - Register 0 never causes a hazard.
- data_stall is defined by FORWARDING_EN (see Configuration).
- FSM states:
  - RUN = 0
  - MEM_WAIT = 1
  - ERR = 2
  - encoding 3 is unused and returns to RUN.
- In RUN, the first matching rule applies:
  1. i_mem_req & ~i_mem_ack: o_pipe_freeze=1, o_pc_hold=1, o_if_id_hold=1, no flush, no bubble; next state MEM_WAIT; wait counter cleared.
  2. i_br_taken: o_if_id_flush=1, o_id_exe_bubble=1, no holds. The PC loads the branch target.
  3. data_stall: o_pc_hold=1, o_if_id_hold=1, o_id_exe_bubble=1.
  4. Otherwise all control outputs are 0.
- MEM_WAIT:
  - While i_mem_ack=0: full freeze, as in rule 1. The wait counter increments.
  - When the wait counter equals MEM_TIMEOUT-1 and i_mem_ack=0: next state ERR.
  - On i_mem_ack=1: next state RUN. Outputs that cycle follow RUN rules 2-4; the memory rule is skipped.
  - A taken branch or hazard pending during the freeze is therefore acted on in the ack cycle.
- ERR:
  - Full freeze, and o_mem_err=1 (sticky).
  - Left only by reset.
- o_stall_cnt:
  - +1 in every cycle with o_pc_hold=1.
  - Saturates at all ones.
- Reset:
  - All control outputs are forced to 0 while i_sys_rst=1.
  - Next state RUN; o_stall_cnt=0, wait counter 0, o_mem_err=0, o_state=0.
  - Reset in MEM_WAIT or ERR returns to RUN on the next edge.

## Timing
- Control outputs are combinational from current inputs and the registered state: zero-cycle response.
- State, wait counter, o_stall_cnt and o_mem_err are registered.
- Load-use hazard (FORWARDING_EN): exactly 1 bubble cycle. The load advances, so data_stall drops on the next cycle.
- Without FORWARDING_EN: a dependency on ID/EXE stalls 2 cycles; a dependency on EXE/MEM stalls 1 cycle.
- Taken branch: 1 flush cycle, which squashes 2 instructions (the ones in IF and in ID).
- ERR is entered after exactly MEM_TIMEOUT consecutive MEM_WAIT cycles without ack.
- Simultaneous memory stall, branch and hazard in RUN: memory wins and the others wait for the ack cycle.

## Configuration
- FORWARDING_EN:
  - Defined: data_stall = (exe_hit1 | exe_hit2) & i_exe_mem_rd_en, i.e. load-use only; the forwarding unit covers everything else.
  - Undefined: data_stall = exe_hit1 | exe_hit2 | mem_hit1 | mem_hit2, with no load qualifier.
  - Interface is identical either way.

## Structure
- Shared defines file: `REG_32_ADDR_LEN, plus `HZ_RUN, `HZ_MEM_WAIT and `HZ_ERR as 2-bit state encodings.
- Sub-module hz_src_match: combinational match of one source against one destination (use, non-zero, wb_en, equality). Instantiated 2 times with FORWARDING_EN, 4 times without.

## Test plan
- Load-use, FORWARDING_EN: ID/EXE holds a load (i_exe_mem_rd_en=1, i_exe_wb_en=1, dest 5), ID src1=5 -> one cycle with o_pc_hold, o_if_id_hold and o_id_exe_bubble all 1; o_stall_cnt=1.
- Register 0, no FORWARDING_EN: i_exe_dest=0, src1=0, i_exe_wb_en=1 -> no stall. With dest 3 / src2=3 via EXE/MEM -> exactly 1 stall cycle.
- Branch: i_br_taken=1 with a hazard also present -> o_if_id_flush=1 and o_id_exe_bubble=1, o_pc_hold=0.
- Memory wait: i_mem_req=1 with ack low for 4 cycles -> o_pipe_freeze=1 for 4 cycles and o_state=1; in the ack cycle i_br_taken=1 -> freeze 0, flush 1, o_state=0 next.
- Timeout: MEM_TIMEOUT=3, ack never asserted -> ERR after 3 MEM_WAIT cycles, o_mem_err=1, freeze held; i_sys_rst pulse -> o_state=0, o_mem_err=0, o_stall_cnt=0.
- Saturation: CNT_W=4 with 20 stall cycles -> o_stall_cnt=15.
